// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA I/O device endpoint.
// Used by dma_io_device and dma_dev_fifo.
package dma_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StAck
    } dev_state_e;

    localparam logic DirDevToMem = 1'b0;  // IOR strobes, FIFO drains to the bus
    localparam logic DirMemToDev = 1'b1;  // IOW strobes, FIFO fills from the bus

    localparam logic [7:0] EmptyReadByte = 8'hFF;

    function automatic logic has_demand(input logic dir, input logic full, input logic empty);
        return (dir == DirMemToDev) ? !full : !empty;
    endfunction

endpackage

// File: rtl/dma_dev_fifo.sv
// Byte FIFO between the DMA bus side and the local valid/ready port.
// Push while full and pop while empty are ignored; the parent flags them.
module dma_dev_fifo
    import dma_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [7:0]             wdata_i,
    input  logic                   pop_i,
    output logic [7:0]             rdata_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [PtrW:0]   count_q;
    logic            do_push, do_pop;

    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (PtrW + 1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dma_io_device.sv
// DMA peripheral endpoint: DREQ/DACK handshake, IOR/IOW strobe data movement and a local FIFO.
// Define DMA_DEV_DEMAND_EN for demand mode (DREQ held across bytes); default is single mode.
module dma_io_device
    import dma_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CHANNEL = 0
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   ENABLE,
    input  logic                   DIR,
    input  logic [3:0]             DACK,
    input  logic                   IOR_N,
    input  logic                   IOW_N,
    input  logic                   EOP_N,
    input  logic [7:0]             DB_IN,
    output logic [3:0]             DREQ,
    output logic [7:0]             DB_OUT,
    output logic                   DB_OE,
    input  logic [7:0]             localWrData,
    input  logic                   localWrValid,
    output logic                   localWrReady,
    output logic [7:0]             localRdData,
    output logic                   localRdValid,
    input  logic                   localRdReady,
    output logic [$clog2(DEPTH):0] count,
    output logic                   tcDone,
    output logic                   protoErr
);

    localparam int unsigned CountW = $clog2(DEPTH) + 1;

    dev_state_e state_q, state_d;
    logic       dir_q, dir_d;
    logic       ior_hist_q, iow_hist_q;
    logic       eop_q, eop_d;
    logic       hold_q, hold_d;
    logic       tc_q, tc_d;
    logic       err_q, err_d;

    logic       dack_ch, eff_dir, ior_rise, iow_rise, strobe_rise, eop_now;
    logic       bus_pop, bus_push, loc_push, loc_pop;
    logic       full, empty;
    logic [7:0] head;
    logic       unused_dack;

    assign unused_dack = ^DACK;
    assign dack_ch     = DACK[CHANNEL[1:0]];
    // Local ports follow the live DIR input only while idle; otherwise the latched direction.
    assign eff_dir     = (state_q == StIdle) ? DIR : dir_q;
    assign ior_rise    = !ior_hist_q && IOR_N;
    assign iow_rise    = !iow_hist_q && IOW_N;
    assign strobe_rise = (dir_q == DirMemToDev) ? iow_rise : ior_rise;
    assign eop_now     = eop_q || !EOP_N;

    assign bus_pop  = (state_q == StAck) && (dir_q == DirDevToMem) && ior_rise;
    assign bus_push = (state_q == StAck) && (dir_q == DirMemToDev) && iow_rise;
    assign loc_push = localWrValid && localWrReady && (eff_dir == DirDevToMem);
    assign loc_pop  = localRdValid && localRdReady && (eff_dir == DirMemToDev);

    dma_dev_fifo #(
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .push_i  (loc_push || bus_push),
        .wdata_i (bus_push ? DB_IN : localWrData),
        .pop_i   (loc_pop || bus_pop),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef DMA_DEV_DEMAND_EN
    logic demand_after;
    assign demand_after = (dir_q == DirDevToMem) ? ((count > CountW'(1)) || loc_push)
                                                 : ((count < CountW'(DEPTH - 1)) || loc_pop);
`endif

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        hold_d  = hold_q && ENABLE;
        tc_d    = 1'b0;
        eop_d   = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                // An unsolicited DACK still opens a bus cycle so the controller can force one.
                if (dack_ch) begin
                    state_d = StAck;
                    dir_d   = DIR;
                end else if (ENABLE && !hold_q && has_demand(DIR, full, empty)) begin
                    state_d = StReq;
                    dir_d   = DIR;
                end
            end
            StReq: begin
                if (dack_ch) state_d = StAck;
            end
            StAck: begin
                eop_d = eop_now;
                if (strobe_rise) begin
                    eop_d = 1'b0;
                    if (eop_now) begin
                        tc_d    = 1'b1;
                        hold_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
`ifdef DMA_DEV_DEMAND_EN
                        state_d = (ENABLE && demand_after) ? StReq : StIdle;
`else
                        state_d = StIdle;
`endif
                    end
                end else if (!dack_ch) begin
                    eop_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if ((bus_pop && empty) || (bus_push && full)) err_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            dir_q      <= DirDevToMem;
            ior_hist_q <= 1'b1;
            iow_hist_q <= 1'b1;
            eop_q      <= 1'b0;
            hold_q     <= 1'b0;
            tc_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            ior_hist_q <= IOR_N;
            iow_hist_q <= IOW_N;
            eop_q      <= eop_d;
            hold_q     <= hold_d;
            tc_q       <= tc_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        DREQ                 = '0;
        DREQ[CHANNEL[1:0]]   = (state_q == StReq);
        DB_OE                = (state_q == StAck) && (dir_q == DirDevToMem) && !IOR_N;
        DB_OUT               = '0;
        if (DB_OE) DB_OUT    = empty ? EmptyReadByte : head;
    end

    assign localWrReady = !full;
    assign localRdValid = !empty;
    assign localRdData  = head;
    assign tcDone       = tc_q;
    assign protoErr     = err_q;

endmodule

// File: doc/dma_io_device.md
# dma_io_device

DMA-capable I/O peripheral model: the requesting end of the DMA controller's DREQ/DACK handshake. It raises DREQ for its channel, waits for the matching DACK bit, and then either supplies a byte on the data bus during an I/O read strobe (device→memory) or captures a byte during an I/O write strobe (memory→device). A local FIFO decouples the bus side from a simple valid/ready local port. It serves as the stimulus/response partner for DMA controller integration benches and as a synthesizable endpoint.

## Interface
- DEPTH, 8, FIFO depth in bytes; power of two, ≥2
- CHANNEL, 0, DMA channel index 0–3; selects which DREQ/DACK bit is used
- CLK  input  1  system clock; all logic on posedge
- RESET_N  input  1  reset, synchronous, active-low
- ENABLE  input  1  device enable; 0 forbids new requests
- DIR  input  1  0 = device→memory (IOR strobes), 1 = memory→device (IOW strobes); latched when leaving IDLE
- DACK  input  4  DMA acknowledge vector from the controller; only bit CHANNEL is used
- IOR_N  input  1  I/O read strobe, active-low
- IOW_N  input  1  I/O write strobe, active-low
- EOP_N  input  1  end of process / terminal count, active-low
- DB_IN  input  8  data bus value (IOW capture)
- DREQ  output  4  DMA request vector; only bit CHANNEL is ever driven high
- DB_OUT  output  8  byte driven during IOR
- DB_OE  output  1  DB_OUT enable
- localWrData / localWrValid / localWrReady  in/in/out  8/1/1  local push into FIFO (DIR=0)
- localRdData / localRdValid / localRdReady  out/out/in  8/1/1  local pop from FIFO (DIR=1)
- count  output  $clog2(DEPTH)+1  FIFO occupancy
- tcDone  output  1  one-cycle pulse when a transfer ends with EOP_N low
- protoErr  output  1  sticky protocol error flag

## Operation
- States: IDLE, REQ, ACK.
- IDLE: DREQ=0. Go to REQ when ENABLE and demand holds: DIR=0 needs count≥1; DIR=1 needs count<DEPTH. DIR is latched on this transition.
- REQ: DREQ[CHANNEL]=1. Go to ACK when DACK[CHANNEL]=1.
- ACK with DIR=0: while IOR_N=0, DB_OE=1 and DB_OUT=FIFO head. Pop on the detected IOR_N rising edge (previous sample 0, current sample 1).
- ACK with DIR=1: capture DB_IN and push on the detected IOW_N rising edge.
- Transfer complete (strobe rising edge seen):
  - If EOP_N was sampled low at any point during ACK: pulse tcDone, go to IDLE, and hold requests off until ENABLE is deasserted and reasserted.
  - Otherwise go to IDLE.
- DACK[CHANNEL] dropping in ACK without a strobe: go to IDLE, no data movement.
- Local ports are active only in the matching direction. Simultaneous local push/pop and bus pop/push are both applied in the same cycle; count is the net result.
- Boundaries:
  - IOR strobe while the FIFO is empty: DB_OUT=8'hFF, no pop, protoErr set.
  - IOW push while full: byte dropped, protoErr set.
  - localWrReady = count<DEPTH; localRdValid = count>0.
  - Pointers wrap modulo DEPTH.
- protoErr clears only on reset.

## Timing
- Reset values: DREQ=0, DB_OE=0, DB_OUT=0, tcDone=0, protoErr=0, count=0, localRdValid=0, localWrReady=1, state=IDLE, strobe history=1.
- DREQ is registered: high one cycle after the demand condition holds in IDLE.
- A strobe edge is detected one cycle after its rising edge. The FIFO update and state return to IDLE happen on that edge.
- DB_OE/DB_OUT are combinational from state, DIR, and IOR_N; no added latency.
- Reset asserted mid-transfer: everything returns to reset values on the next edge. The in-flight byte is neither popped nor pushed.

## Configuration
- DMA_DEV_DEMAND_EN defined: demand mode. At transfer completion without EOP, the block goes directly to REQ with DREQ kept high if the demand condition still holds, so DREQ stays asserted across bytes.
- DMA_DEV_DEMAND_EN undefined: single mode. DREQ drops for at least one cycle after every byte (ACK→IDLE→REQ).

## Structure
- Shared package dma_pkg:
  - device state enum (IDLE/REQ/ACK)
  - DIR encodings
  - the 8'hFF empty-read constant
- Sub-module dma_dev_fifo: synchronous FIFO with push, pop, count, full and empty. The parent holds the FSM and strobe edge detection.

## Test plan
- DIR=0, push 8'hA5 locally → DREQ[CHANNEL]=1 next cycle; DACK then an IOR pulse → DB_OUT=8'hA5 with DB_OE high while IOR_N low; count 1→0; DREQ low.
- DIR=1, DEPTH=8, five IOW cycles with DB_IN=1..5 → count=5; localRdData reads 1,2,3,4,5 in order.
- EOP_N low during the third transfer → tcDone pulses once, DREQ stays 0 until an ENABLE toggle.
- Demand build, four bytes queued, DIR=0 → DREQ stays high through four transfers and drops after the last pop. Single build → DREQ low for ≥1 cycle between bytes.
- IOR with empty FIFO (forced DACK) → DB_OUT=8'hFF, count unchanged, protoErr=1. Eight IOW pushes into a full FIFO → the ninth byte is dropped and protoErr=1.
- RESET_N low in ACK with IOR_N low → next cycle DREQ=0, DB_OE=0, count=0, state IDLE.
